// File: rtl/gf180mcu_osu_sc_gp12t3v3__bist_pkg.sv
// Shared types and the Galois step used by the buffer-bank BIST pattern generator and MISR.
package gf180mcu_osu_sc_gp12t3v3__bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_e;

   localparam int         MAX_W         = 32;
   localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
   localparam logic [7:0] MISR_TAPS_DEF = 8'h8E;

   // Computed at MAX_W so any register up to that width can share it; callers zero-extend.
   function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] s,
                                                     input logic [MAX_W-1:0] m);
      return (s >> 1) ^ (s[0] ? m : '0);
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__bist_shreg.sv
// Galois shift register with synchronous load; serves as both the pattern LFSR and the MISR.
module gf180mcu_osu_sc_gp12t3v3__bist_shreg
   import gf180mcu_osu_sc_gp12t3v3__bist_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] taps,
   input  logic [WIDTH-1:0] xin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nxt
);

   logic [MAX_W-1:0] step_full;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             step_hi_unused;

   always_comb begin
      step_full = galois_step(MAX_W'(q_q), MAX_W'(taps));
      nxt       = step_full[WIDTH-1:0] ^ xin;
      q_d       = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = nxt;
      end
   end

   // Upper bits are always zero because both operands are zero-extended.
   assign step_hi_unused = ^step_full[MAX_W-1:WIDTH];

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__buf_bist.sv
// BIST wrapper for a bank of buffer cells: LFSR drives A, MISR compacts Y, signature compared to GOLDEN.
//   state   | meaning
//   ST_IDLE | LFSR/MISR hold load values, waiting for START
//   ST_RUN  | one pattern per cycle, MISR absorbs Y, counting to N_PAT
//   ST_DONE | signature and PASS held until START or ABORT
module gf180mcu_osu_sc_gp12t3v3__buf_bist
   import gf180mcu_osu_sc_gp12t3v3__bist_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               N_PAT     = 255,
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(LFSR_TAPS_DEF),
   parameter logic [WIDTH-1:0] MISR_TAPS = WIDTH'(MISR_TAPS_DEF),
   parameter logic [WIDTH-1:0] MISR_INIT = '1,
   parameter logic [WIDTH-1:0] GOLDEN    = '0
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ABORT,
   output logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] Y,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [WIDTH-1:0] SIG
);

   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [15:0]      LAST_CNT = 16'(N_PAT - 1);

   bist_state_e      state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             busy_q, done_q;
   logic             launch, reload, run_en;
   logic [WIDTH-1:0] misr_nxt;
   logic [WIDTH-1:0] lfsr_nxt_unused;

   assign launch = START && (state_q == ST_IDLE || state_q == ST_DONE);
   assign reload = !RN || ABORT || launch;
   assign run_en = (state_q == ST_RUN);

   gf180mcu_osu_sc_gp12t3v3__bist_shreg #(.WIDTH(WIDTH)) u_lfsr (
      .clk      (CLK),
      .load     (reload),
      .load_val (SEED_EFF),
      .en       (run_en),
      .taps     (LFSR_TAPS),
      .xin      ('0),
      .q        (A),
      .nxt      (lfsr_nxt_unused)
   );

   gf180mcu_osu_sc_gp12t3v3__bist_shreg #(.WIDTH(WIDTH)) u_misr (
      .clk      (CLK),
      .load     (reload),
      .load_val (MISR_INIT),
      .en       (run_en),
      .taps     (MISR_TAPS),
      .xin      (Y),
      .q        (SIG),
      .nxt      (misr_nxt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      if (!RN || ABORT) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  pass_d  = (misr_nxt == GOLDEN);
               end
            end
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  pass_d  = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign PASS = pass_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__buf_bist.sv
// Self-checking bench: directed test-plan scenarios plus random Y corruption against a run-level model.
module tb_gf180mcu_osu_sc_gp12t3v3__buf_bist;

   logic       CLK = 1'b0;
   logic       RN, START, ABORT;
   logic       y_stuck;
   logic [7:0] y_mask;
   logic [7:0] a_dut, y_dut, sig_dut;
   logic       busy_dut, done_dut, pass_dut;
   logic [7:0] l_a, l_sig;
   logic       l_busy, l_done, l_pass;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 CLK = ~CLK;

   assign y_dut = y_stuck ? 8'h00 : (a_dut ^ y_mask);

   gf180mcu_osu_sc_gp12t3v3__buf_bist #(.N_PAT(4), .GOLDEN(8'h30)) u_dut (
      .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT),
      .A(a_dut), .Y(y_dut), .BUSY(busy_dut), .DONE(done_dut), .PASS(pass_dut), .SIG(sig_dut)
   );

   gf180mcu_osu_sc_gp12t3v3__buf_bist #(.N_PAT(6)) u_long (
      .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT),
      .A(l_a), .Y(l_a), .BUSY(l_busy), .DONE(l_done), .PASS(l_pass), .SIG(l_sig)
   );

   function automatic logic [7:0] gstep(input logic [7:0] s, input logic [7:0] m);
      return (s >> 1) ^ (s[0] ? m : 8'h00);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy_dut, 1'b0);
      check({tag, "_done"}, done_dut, 1'b0);
      check({tag, "_pass"}, pass_dut, 1'b0);
      check({tag, "_a"},    a_dut,    8'h01);
      check({tag, "_sig"},  sig_dut,  8'hFF);
   endtask

   // Entered at the falling edge of the first RUN cycle; leaves at the falling edge in DONE or IDLE.
   task automatic run_cycles(input bit stuck, input bit rnd, input int abort_at);
      logic [7:0] a_exp, s_exp, y_exp;
      a_exp = 8'h01;
      s_exp = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         check("run_busy", busy_dut, 1'b1);
         check("run_done", done_dut, 1'b0);
         check("run_a", a_dut, a_exp);
         if (i == 0) check("pass_clr", pass_dut, 1'b0);
         if (i == abort_at) begin
            ABORT = 1'b1;
            @(negedge CLK);
            ABORT = 1'b0;
            check_idle("abort");
            y_stuck = 1'b0;
            y_mask  = 8'h00;
            return;
         end
         y_stuck = stuck;
         y_mask  = rnd ? 8'($urandom) : 8'h00;
         y_exp   = stuck ? 8'h00 : (a_exp ^ y_mask);
         s_exp   = gstep(s_exp, 8'h8E) ^ y_exp;
         a_exp   = gstep(a_exp, 8'hB8);
         @(negedge CLK);
      end
      check("end_done", done_dut, 1'b1);
      check("end_busy", busy_dut, 1'b0);
      check("end_sig", sig_dut, s_exp);
      check("end_pass", pass_dut, s_exp == 8'h30);
      check("end_a", a_dut, a_exp);
      y_stuck = 1'b0;
      y_mask  = 8'h00;
   endtask

   task automatic run_one(input bit stuck, input bit rnd, input int abort_at);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      run_cycles(stuck, rnd, abort_at);
   endtask

   initial begin
      logic [7:0] pat [6];
      logic [7:0] ls, la;
      int         ab;
      pat = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
      RN = 1'b0; START = 1'b0; ABORT = 1'b0; y_stuck = 1'b0; y_mask = 8'h00;
      repeat (2) @(negedge CLK);
      check_idle("reset");
      RN = 1'b1;
      @(negedge CLK);

      // Pattern sequence on the 6-pattern instance, Y tied to A.
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      ls = 8'hFF;
      la = 8'h01;
      for (int i = 0; i < 6; i++) begin
         check("pat_busy", l_busy, 1'b1);
         check("pat_a", l_a, pat[i]);
         ls = gstep(ls, 8'h8E) ^ la;
         la = gstep(la, 8'hB8);
         @(negedge CLK);
      end
      check("pat_done", l_done, 1'b1);
      check("pat_sig", l_sig, ls);
      check("pat_pass", l_pass, ls == 8'h00);

      // Good buffer, then stuck-at-0 with DONE hold.
      run_one(1'b0, 1'b0, -1);
      check("good_sig", sig_dut, 8'h30);
      check("good_pass", pass_dut, 1'b1);
      run_one(1'b1, 1'b0, -1);
      check("stuck_sig", sig_dut, 8'hB3);
      @(negedge CLK);
      check("hold_done", done_dut, 1'b1);
      check("hold_sig", sig_dut, 8'hB3);
      check("hold_pass", pass_dut, 1'b0);

      // Abort in the second RUN cycle, then a clean run.
      run_one(1'b0, 1'b0, 1);
      @(negedge CLK);
      check_idle("idle_stay");
      run_one(1'b0, 1'b0, -1);
      check("post_abort_pass", pass_dut, 1'b1);

      // Reset mid-run with START held high.
      START = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RN = 1'b0;
      @(negedge CLK);
      check_idle("rst_run");
      RN = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      run_cycles(1'b0, 1'b0, -1);

      // Back-to-back runs with START held.
      START = 1'b1;
      @(negedge CLK);
      run_cycles(1'b0, 1'b0, -1);
      @(negedge CLK);
      run_cycles(1'b0, 1'b0, -1);
      START = 1'b0;

      // Random Y corruption with occasional aborts.
      for (int k = 0; k < 24; k++) begin
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_one(1'b0, 1'b1, ab);
         if ($urandom_range(0, 1) == 1) @(negedge CLK);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__buf_bist.md
# gf180mcu_osu_sc_gp12t3v3__buf_bist

Built-in self-test wrapper for a bank of `WIDTH` buffer cells in the gp12t3v3 library. It sits around the cells under test:
- **Upstream:** an LFSR pattern generator drives the cell inputs.
- **Downstream:** a MISR compacts the cell outputs.
- **Result:** after `N_PAT` patterns, the MISR signature is compared with a golden value, and the result is reported as `PASS`/`DONE`.

## Interface
- `WIDTH`, 8: number of cell lanes; sets the LFSR, MISR and `SIG` width.
- `N_PAT`, 255: patterns applied per run. Legal range is 1..65535.
- `SEED`, 8'h01: LFSR load value. A value of 0 is illegal and is replaced by 1 at load.
- `LFSR_TAPS`, 8'hB8: Galois XOR mask for the pattern LFSR.
- `MISR_TAPS`, 8'h8E: Galois XOR mask for the MISR.
- `MISR_INIT`, all-ones: MISR load value.
- `GOLDEN`, 8'h00: expected signature.
- `CLK` input 1: sole clock; all state updates on the rising edge.
- `RN` input 1: reset, synchronous and active-low.
- `START` input 1: level; begins a run when sampled high in IDLE or DONE.
- `ABORT` input 1: level; returns the block to IDLE from any state. Takes priority over `START`.
- `A` output WIDTH: drives the inputs of the cells under test. Always equals the LFSR register.
- `Y` input WIDTH: cell outputs, sampled at each RUN edge.
- `BUSY` output 1: high in RUN.
- `DONE` output 1: high in DONE.
- `PASS` output 1: valid while `DONE`=1; 1 if the signature matched `GOLDEN`.
- `SIG` output WIDTH: current MISR contents.

## Operation
- **Galois step:** `step(s, m) = (s >> 1) ^ (s[0] ? m : 0)`.
- **States:** IDLE, RUN, DONE.
- **Reset** (`RN`=0 at an edge):
  - state=IDLE.
  - LFSR=`SEED`, MISR=`MISR_INIT`, count=0.
  - `BUSY`=`DONE`=`PASS`=0.
  - `A`=`SEED`, `SIG`=`MISR_INIT`.
- **IDLE + `START`:**
  - load LFSR=`SEED`, MISR=`MISR_INIT`, count=0;
  - clear `PASS`;
  - go to RUN.
- **RUN, each edge:**
  - MISR ← `step(MISR, MISR_TAPS) ^ Y`.
  - LFSR ← `step(LFSR, LFSR_TAPS)`.
  - count ← count+1.
- **RUN, edge where count == `N_PAT`-1:**
  - the MISR update above still happens;
  - go to DONE;
  - `PASS` ← (new MISR == `GOLDEN`).
- **DONE:**
  - hold LFSR, MISR and `PASS`.
  - `START` high → reload as from IDLE and go to RUN, allowing back-to-back runs.
  - `START` low → stay in DONE.
- **ABORT** (any state): go to IDLE and reload as at reset, except that `RN` is not required.
- `START` is ignored while in RUN.
- `RN` low during RUN abandons the run; the next edge shows the reset values.
- The counter is 16 bits and is never compared beyond `N_PAT`-1, so it never wraps.

## Timing
- `A` changes only on `CLK` edges.
- The cell path `A`→`Y` is combinational, so `Y` is sampled in the same cycle that `A` presents each pattern.
- **Latency:** `START` sampled at edge 0 → `BUSY`=1 after edge 0 → `DONE`=1 after edge `N_PAT`. `BUSY` is high for exactly `N_PAT` cycles.
- `PASS` and `DONE` become valid on the same edge.

## Structure
- **Package `gf180mcu_osu_sc_gp12t3v3__bist_pkg`:**
  - state enum (IDLE/RUN/DONE);
  - `galois_step` function;
  - default tap constants 8'hB8 and 8'h8E.
- **Sub-module `gf180mcu_osu_sc_gp12t3v3__bist_shreg`:**
  - WIDTH-bit Galois register with ports `load`, `load_val`, `en`, `taps`, `xin`;
  - instantiated twice: as the LFSR with `xin`=0, and as the MISR with `xin`=`Y`.
- **Top level:** FSM, counter and compare.

## Test plan
- **Pattern sequence:** after reset, `START` for one cycle. `A` must read 01, B8, 5C, 2E, 17, B3 in consecutive RUN cycles.
- **Good signature:** `N_PAT`=4, `Y`=`A` (good buffer), `GOLDEN`=8'h30. Expect `DONE`=1 after edge 4, `SIG`=8'h30, `PASS`=1.
- **Stuck-at-0 fault:** same parameters with `Y` forced to 8'h00. Expect `SIG`=8'hB3, `PASS`=0.
- **Abort mid-run:** `ABORT` in the 2nd RUN cycle. Expect IDLE, `BUSY`=0, `A`=01, `SIG`=FF next cycle. A following `START` completes normally with `PASS`=1.
- **Reset mid-run:** `RN` low in RUN with `START` held high. Expect all outputs at reset values; `START` then relaunches the run.
- **Back-to-back runs:** `START` high continuously. Expect DONE for one cycle, RUN restarts with `A`=01, and the second run yields the same `SIG`/`PASS`.
